c_v_stream: RTL and testbench



---
 rtl/c_pkg.sv | 26 ++
 rtl/c_v.sv | 19 +
 rtl/c_v_stream.sv | 154 +++++++++++++++
 tb/tb_c_v_stream.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/c_pkg.sv
// Shared types for the c_v_stream thermometer-code admission controller.
// Optional build macro used by the top: C_V_STREAM_LEN_EN (length accumulator).
package c_pkg;

    typedef enum logic [1:0] {
        RUN_ONES  = 2'd0,
        RUN_ZEROS = 2'd1,
        FAIL      = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ONES = 2'd0,
        ZERO = 2'd1,
        PART = 2'd2,
        BAD  = 2'd3
    } beat_cls_e;

    function automatic int len_width(input int max_beats, input int w);
        return $clog2(max_beats * w + 1);
    endfunction

    function automatic int cnt_width(input int max_beats);
        return (max_beats > 1) ? $clog2(max_beats) : 1;
    endfunction

endpackage

// File: rtl/c_v.sv
// Single-beat thermometer classifier: flags a 0*1* beat (1*0* when complemented)
// and the degenerate all-set beat, which is reported separately.
module c_v #(
    parameter int W               = 16,
    parameter int P_IS_COMPLIMENT = 0
) (
    input  logic [W-1:0] i_x,
    output logic         o_is_unary,
    output logic         o_all_set
);

    logic [W-1:0] xp;

    assign xp        = (P_IS_COMPLIMENT != 0) ? ~i_x : i_x;
    assign o_all_set = &xp;
    // Ones contiguous from bit 0 iff adding one clears every set bit.
    assign o_is_unary = ~|(xp & (xp + W'(1))) & ~o_all_set;

endmodule

// File: rtl/c_v_stream.sv
// Multi-beat thermometer-code admission controller, one registered verdict per code.
// Define C_V_STREAM_LEN_EN to build the run-length accumulator; otherwise o_res_len is 0.
module c_v_stream
    import c_pkg::*;
#(
    parameter  int W               = 16,
    parameter  int P_MAX_BEATS     = 8,
    parameter  int P_IS_COMPLIMENT = 0,
    localparam int LW              = len_width(P_MAX_BEATS, W)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          i_vld,
    input  logic [W-1:0]  i_x,
    input  logic          i_last,
    output logic          o_rdy,
    output logic          o_res_vld,
    input  logic          i_res_rdy,
    output logic          o_res_is_unary,
    output logic          o_res_all_set,
    output logic [LW-1:0] o_res_len,
    output logic          o_res_ovf
);

    localparam int CW = cnt_width(P_MAX_BEATS);
    localparam logic [CW-1:0] CNT_MAX = CW'(P_MAX_BEATS - 1);

    state_e        state, state_nxt, state_d;
    beat_cls_e     cls;
    logic [CW-1:0] cnt;
    logic          ovf, ovf_nxt;
    logic [W-1:0]  xp;
    logic          cv_unary, cv_all_set;
    logic          accept, last_acc;

    assign o_rdy    = ~o_res_vld | i_res_rdy;
    assign accept   = i_vld & o_rdy;
    assign last_acc = accept & i_last;
    assign xp       = (P_IS_COMPLIMENT != 0) ? ~i_x : i_x;

    c_v #(
        .W               (W),
        .P_IS_COMPLIMENT (P_IS_COMPLIMENT)
    ) u_c_v (
        .i_x        (i_x),
        .o_is_unary (cv_unary),
        .o_all_set  (cv_all_set)
    );

    always_comb begin
        if (cv_all_set)    cls = ONES;
        else if (~|xp)     cls = ZERO;
        else if (cv_unary) cls = PART;
        else               cls = BAD;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= RUN_ONES;
        else         state <= state_d;
    end

    always_comb begin
        state_nxt = state;
        ovf_nxt   = ovf;
        state_d   = state;
        case (state)
            RUN_ONES: begin
                case (cls)
                    ONES:       state_nxt = RUN_ONES;
                    PART, ZERO: state_nxt = RUN_ZEROS;
                    default:    state_nxt = FAIL;
                endcase
            end
            RUN_ZEROS: if (cls != ZERO) state_nxt = FAIL;
            default:   state_nxt = FAIL;
        endcase
        // A non-final beat in the last permitted slot means the code is too long.
        if (!i_last && cnt == CNT_MAX) begin
            state_nxt = FAIL;
            ovf_nxt   = 1'b1;
        end
        if (accept) state_d = i_last ? RUN_ONES : state_nxt;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            if (i_last) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                ovf <= ovf_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_res_vld      <= 1'b0;
            o_res_is_unary <= 1'b0;
            o_res_all_set  <= 1'b0;
            o_res_ovf      <= 1'b0;
        end else if (last_acc) begin
            o_res_vld      <= 1'b1;
            o_res_is_unary <= (state_nxt == RUN_ZEROS);
            o_res_all_set  <= (state_nxt == RUN_ONES);
            o_res_ovf      <= ovf_nxt;
        end else if (i_res_rdy) begin
            o_res_vld <= 1'b0;
        end
    end

`ifdef C_V_STREAM_LEN_EN
    logic [LW-1:0] len, len_nxt, res_len;

    function automatic logic [LW-1:0] trail_ones(input logic [W-1:0] v);
        logic [LW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (run && v[i]) n = n + 1'b1;
            else             run = 1'b0;
        end
        return n;
    endfunction

    always_comb begin
        len_nxt = len;
        if (state == RUN_ONES) begin
            if (cls == ONES)      len_nxt = len + LW'(W);
            else if (cls == PART) len_nxt = len + trail_ones(xp);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            len     <= '0;
            res_len <= '0;
        end else if (accept) begin
            len <= i_last ? '0 : len_nxt;
            if (i_last) res_len <= (state_nxt == FAIL) ? '0 : len_nxt;
        end
    end

    assign o_res_len = res_len;
`else
    assign o_res_len = '0;
`endif

endmodule

// File: tb/tb_c_v_stream.sv
// Directed bench for c_v_stream: W=4, P_MAX_BEATS=4, plain and complemented instances.
module tb_c_v_stream;

    localparam int W  = 4;
    localparam int PM = 4;
    localparam int LW = 5;
`ifdef C_V_STREAM_LEN_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic          clk;
    logic          arst_n, arst_n_b;
    logic          vld, last, res_rdy, rdy, res_vld, is_unary, all_set, ovf;
    logic [W-1:0]  x;
    logic [LW-1:0] len;
    logic          vld_b, last_b, res_rdy_b, rdy_b, res_vld_b, is_unary_b, all_set_b, ovf_b;
    logic [W-1:0]  x_b;
    logic [LW-1:0] len_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]   beats;
        int            n;
        logic          u;
        logic          a;
        logic [LW-1:0] l;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    c_v_stream #(.W(W), .P_MAX_BEATS(PM), .P_IS_COMPLIMENT(0)) dut_a (
        .clk(clk), .arst_n(arst_n), .i_vld(vld), .i_x(x), .i_last(last),
        .o_rdy(rdy), .o_res_vld(res_vld), .i_res_rdy(res_rdy),
        .o_res_is_unary(is_unary), .o_res_all_set(all_set),
        .o_res_len(len), .o_res_ovf(ovf)
    );

    c_v_stream #(.W(W), .P_MAX_BEATS(PM), .P_IS_COMPLIMENT(1)) dut_b (
        .clk(clk), .arst_n(arst_n_b), .i_vld(vld_b), .i_x(x_b), .i_last(last_b),
        .o_rdy(rdy_b), .o_res_vld(res_vld_b), .i_res_rdy(res_rdy_b),
        .o_res_is_unary(is_unary_b), .o_res_all_set(all_set_b),
        .o_res_len(len_b), .o_res_ovf(ovf_b)
    );

    function automatic logic [LW-1:0] exp_len(input logic [LW-1:0] l);
        return LEN_EN ? l : '0;
    endfunction

    task automatic send_a(input logic [W-1:0] bx, input logic bl);
        @(negedge clk);
        vld = 1'b1; x = bx; last = bl;
    endtask

    task automatic send_b(input logic [W-1:0] bx, input logic bl);
        @(negedge clk);
        vld_b = 1'b1; x_b = bx; last_b = bl;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; arst_n_b = 1'b0;
        vld = 1'b0; x = '0; last = 1'b0; res_rdy = 1'b1;
        vld_b = 1'b0; x_b = '0; last_b = 1'b0; res_rdy_b = 1'b1;
        @(negedge clk);
        checks++; if (rdy !== 1'b1)     begin errors++; $display("FAIL reset rdy got %b exp 1", rdy); end
        checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL reset res_vld got %b exp 0", res_vld); end
        checks++; if ({is_unary, all_set, ovf} !== 3'b000) begin errors++; $display("FAIL reset flags got %b exp 000", {is_unary, all_set, ovf}); end
        checks++; if (len !== '0)       begin errors++; $display("FAIL reset len got %0d exp 0", len); end
        @(negedge clk);
        arst_n = 1'b1; arst_n_b = 1'b1;
    endtask

    task automatic test_codes();
        vec_t v[9];
        v[0] = '{32'h0000_003F, 2, 1'b1, 1'b0, 5'd6};
        v[1] = '{32'h0000_00FF, 2, 1'b0, 1'b1, 5'd8};
        v[2] = '{32'h0000_0013, 2, 1'b0, 1'b0, 5'd0};
        v[3] = '{32'h0000_0005, 1, 1'b0, 1'b0, 5'd0};
        v[4] = '{32'h0000_0000, 1, 1'b1, 1'b0, 5'd0};
        v[5] = '{32'h0000_1FFF, 4, 1'b1, 1'b0, 5'd13};
        v[6] = '{32'h0000_FFFF, 4, 1'b0, 1'b1, 5'd16};
        v[7] = '{32'h0000_00F0, 2, 1'b0, 1'b0, 5'd0};
        v[8] = '{32'h0000_0007, 3, 1'b1, 1'b0, 5'd3};
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < v[i].n; k++) send_a(v[i].beats[4*k +: 4], k == v[i].n - 1);
            @(negedge clk);
            vld = 1'b0; last = 1'b0;
            checks++; if (res_vld !== 1'b1)   begin errors++; $display("FAIL code%0d res_vld got %b exp 1", i, res_vld); end
            checks++; if (is_unary !== v[i].u) begin errors++; $display("FAIL code%0d is_unary got %b exp %b", i, is_unary, v[i].u); end
            checks++; if (all_set !== v[i].a)  begin errors++; $display("FAIL code%0d all_set got %b exp %b", i, all_set, v[i].a); end
            checks++; if (len !== exp_len(v[i].l)) begin errors++; $display("FAIL code%0d len got %0d exp %0d", i, len, exp_len(v[i].l)); end
            checks++; if (ovf !== 1'b0)        begin errors++; $display("FAIL code%0d ovf got %b exp 0", i, ovf); end
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 5; k++) send_a(4'hF, k == 4);
        @(negedge clk);
        vld = 1'b0; last = 1'b0;
        checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL ovf res_vld got %b exp 1", res_vld); end
        checks++; if (ovf !== 1'b1)     begin errors++; $display("FAIL ovf flag got %b exp 1", ovf); end
        checks++; if ({is_unary, all_set} !== 2'b00) begin errors++; $display("FAIL ovf u/a got %b exp 00", {is_unary, all_set}); end
        checks++; if (len !== '0)       begin errors++; $display("FAIL ovf len got %0d exp 0", len); end
        send_a(4'h1, 1'b1);
        @(negedge clk);
        vld = 1'b0; last = 1'b0;
        checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL post_ovf ovf got %b exp 0", ovf); end
        checks++; if (is_unary !== 1'b1) begin errors++; $display("FAIL post_ovf is_unary got %b exp 1", is_unary); end
        checks++; if (len !== exp_len(5'd1)) begin errors++; $display("FAIL post_ovf len got %0d exp %0d", len, exp_len(5'd1)); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        res_rdy = 1'b0;
        send_a(4'hF, 1'b0);
        send_a(4'h3, 1'b1);
        @(negedge clk);
        vld = 1'b1; x = 4'hF; last = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (rdy !== 1'b0)      begin errors++; $display("FAIL hold%0d rdy got %b exp 0", c, rdy); end
            checks++; if (res_vld !== 1'b1)  begin errors++; $display("FAIL hold%0d res_vld got %b exp 1", c, res_vld); end
            checks++; if ({is_unary, all_set} !== 2'b10) begin errors++; $display("FAIL hold%0d u/a got %b exp 10", c, {is_unary, all_set}); end
            checks++; if (len !== exp_len(5'd6)) begin errors++; $display("FAIL hold%0d len got %0d exp %0d", c, len, exp_len(5'd6)); end
            @(negedge clk);
        end
        res_rdy = 1'b1;
        #1;
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL release rdy got %b exp 1", rdy); end
        @(negedge clk);
        vld = 1'b0; last = 1'b0;
        checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL b2b res_vld got %b exp 1", res_vld); end
        checks++; if ({is_unary, all_set} !== 2'b01) begin errors++; $display("FAIL b2b u/a got %b exp 01", {is_unary, all_set}); end
        checks++; if (len !== exp_len(5'd4)) begin errors++; $display("FAIL b2b len got %0d exp %0d", len, exp_len(5'd4)); end
        @(negedge clk);
        checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL drained res_vld got %b exp 0", res_vld); end
    endtask

    task automatic test_complement();
        send_b(4'h0, 1'b0);
        send_b(4'hC, 1'b1);
        @(negedge clk);
        vld_b = 1'b0; last_b = 1'b0; res_rdy_b = 1'b0;
        checks++; if (res_vld_b !== 1'b1) begin errors++; $display("FAIL cmp res_vld got %b exp 1", res_vld_b); end
        checks++; if ({is_unary_b, all_set_b, ovf_b} !== 3'b100) begin errors++; $display("FAIL cmp flags got %b exp 100", {is_unary_b, all_set_b, ovf_b}); end
        checks++; if (len_b !== exp_len(5'd6)) begin errors++; $display("FAIL cmp len got %0d exp %0d", len_b, exp_len(5'd6)); end
        @(negedge clk);
        arst_n_b = 1'b0;
        #1;
        checks++; if ({res_vld_b, is_unary_b, all_set_b, ovf_b} !== 4'b0000) begin errors++; $display("FAIL arst outs got %b exp 0000", {res_vld_b, is_unary_b, all_set_b, ovf_b}); end
        checks++; if (len_b !== '0)  begin errors++; $display("FAIL arst len got %0d exp 0", len_b); end
        checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL arst rdy got %b exp 1", rdy_b); end
        #1;
        arst_n_b = 1'b1;
        res_rdy_b = 1'b1;
        send_b(4'h0, 1'b0);
        @(negedge clk);
        vld_b = 1'b0;
        arst_n_b = 1'b0;
        #2;
        arst_n_b = 1'b1;
        send_b(4'hC, 1'b1);
        @(negedge clk);
        vld_b = 1'b0; last_b = 1'b0;
        checks++; if ({res_vld_b, is_unary_b, all_set_b} !== 3'b110) begin errors++; $display("FAIL fresh flags got %b exp 110", {res_vld_b, is_unary_b, all_set_b}); end
        checks++; if (len_b !== exp_len(5'd2)) begin errors++; $display("FAIL fresh len got %0d exp %0d", len_b, exp_len(5'd2)); end
    endtask

    initial begin
        test_reset();
        test_codes();
        test_overflow();
        test_back_to_back();
        test_complement();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
